call_scheduler: RTL and testbench
=================================

CALL_SCHEDULER -- requirements
Module: call_scheduler

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 3: consecutive synchronised-high cycles needed to accept a button press.
REQ-002 clk  input  1  sole clock; all state rising-edge; the divided elevator clock also driving movement.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 button1, button2, button3  input  1 each  raw floor-call buttons, asynchronous, bouncy, high = pressed.
REQ-005 floor1, floor2, floor3  input  1 each  current-floor one-hot from movement; all-low = between floors.
REQ-006 door  input  1  high = door open (from movement).
REQ-007 moving  input  1  high = cab in motion (from movement).
REQ-008 led1, led2, led3  output  1 each  pending-call indicators, registered.
REQ-009 target  output  2  next floor to serve: 0 none, 1..3 floor number, registered.
REQ-010 target_valid  output  1  high when target is nonzero.
REQ-011 dir  output  2  00 IDLE, 01 UP, 10 DOWN.

Function
REQ-012 Each button SHALL pass a 2-flop synchroniser, then a debounce counter: debounced level rises after DEBOUNCE_CYCLES consecutive synchronised-high cycles, falls on first synchronised-low cycle.
REQ-013 Rising edge of a debounced level SHALL produce a one-cycle press pulse; holding a button SHALL produce no further pulses.
REQ-014 Press pulse for floor F SHALL set pending[F] next cycle, unless last_floor==F and door==1 (call already served; ignored).
REQ-015 pending[F] SHALL clear next cycle when floorF==1, door==1, moving==0; a simultaneous set and clear for F resolves to clear.
REQ-016 ledF SHALL equal pending[F].
REQ-017 last_floor register SHALL update only when floor1..3 is exactly one-hot; all-low or multi-hot inputs hold last_floor.
REQ-018 Direction FSM states IDLE, UP, DOWN; transitions evaluated every cycle on pending and last_floor:
REQ-019 IDLE: pending above -> UP; else pending below -> DOWN; else stay (call at current floor keeps IDLE).
REQ-020 UP: no pending above -> DOWN if pending below, else IDLE; DOWN symmetric (no pending below -> UP if pending above, else IDLE).
REQ-021 target SHALL be nearest pending floor in current direction; in IDLE, pending[last_floor] -> target=last_floor, else 0.
REQ-022 target, target_valid, dir SHALL be registered, reflecting a pending/floor change one cycle after that change is registered.
REQ-023 Floor arithmetic SHALL use 2-bit unsigned floor numbers 1..3; value 0 never denotes a floor.

Reset
REQ-024 rst_n low SHALL immediately force: synchronisers, debounce counters, pending = 0; led1..3 = 0; target = 0; target_valid = 0; dir = IDLE; last_floor = 1.
REQ-025 Reset mid-operation SHALL discard all pending calls and partial debounce counts; no pulse SHALL be generated from a button already held when rst_n deasserts until it has been seen low then held high for DEBOUNCE_CYCLES.

Structure
REQ-026 Shared package elevator_pkg SHALL hold NUM_FLOORS=3, floor-number constants, FLOOR_NONE=0, and the dir encoding IDLE/UP/DOWN; movement SHALL use the same package.
REQ-027 One sub-module button_debouncer (synchroniser + counter + edge pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated three times.
REQ-028 call_scheduler SHALL sit between raw buttons and movement inside the top level, driving movement's target inputs.

Verification (DEBOUNCE_CYCLES=3)
REQ-029 Bounce: button2 high 2 cycles, low 1, high 2, low -> led2 stays 0; then held high 6 cycles -> led2=1 exactly 2+3+1 cycles after the final rise.
REQ-030 Sweep: floor1 idle, door=0, press button3 then button2 -> dir=UP, target=3 then 2; at floor2 with door=1, moving=0 -> led2 clears, target=3.
REQ-031 Reversal: last_floor=2, dir=UP, pending only floor1 -> dir=DOWN, target=1 one cycle later.
REQ-032 Served call: floor1=1, door=1, press button1 -> led1 remains 0, target remains 0.
REQ-033 Between floors: floor inputs 000 while moving=1, pending floor3 -> last_floor, target=3, dir=UP all held.
REQ-034 Async reset: pending=101, dir=UP, drop rst_n between clock edges -> led1..3=0, target=0, dir=IDLE before next edge.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor numbering and direction encoding
// used by both the call scheduler and the movement controller.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 3;

    typedef logic [1:0] floor_t;

    localparam floor_t FLOOR_NONE = 2'd0;
    localparam floor_t FLOOR_1    = 2'd1;
    localparam floor_t FLOOR_2    = 2'd2;
    localparam floor_t FLOOR_3    = 2'd3;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    // Only meaningful for a one-hot vector; callers gate with $onehot.
    function automatic floor_t onehot_to_floor(input logic [NUM_FLOORS-1:0] vec);
        floor_t f;
        f = FLOOR_NONE;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (vec[i]) f = floor_t'(i + 1);
        end
        return f;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button conditioning: 2-flop synchroniser, debounce counter and a
// single-cycle press pulse on the rising edge of the debounced level.
module button_debouncer
    import elevator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync0;
    logic          sync1;
    logic [1:0]    fill;
    logic          armed;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_q;

    // armed stays low until a genuine low sample has passed the synchroniser,
    // so a button held through reset cannot generate a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            fill    <= '0;
            armed   <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync0   <= button;
            sync1   <= sync0;
            fill    <= {fill[0], 1'b1};
            level_q <= level;
            if (fill[1] && !sync1) armed <= 1'b1;
            if (!sync1 || !armed) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (cnt != CW'(DEBOUNCE_CYCLES)) begin
                cnt <= cnt + 1'b1;
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) level <= 1'b1;
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/call_scheduler.sv
// Floor-call scheduler: debounces the call buttons, tracks pending calls and
// the last visited floor, and picks the direction and next target floor.
module call_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       floor1,
    input  logic       floor2,
    input  logic       floor3,
    input  logic       door,
    input  logic       moving,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic [1:0] target,
    output logic       target_valid,
    output logic [1:0] dir
);

    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] pending;
    logic [NUM_FLOORS-1:0] set_req;
    logic [NUM_FLOORS-1:0] clr_req;
    logic [NUM_FLOORS-1:0] floor_vec;
    floor_t                last_floor;
    floor_t                up_tgt;
    floor_t                dn_tgt;
    logic                  here_pending;
    floor_t                target_next;
    dir_t                  dir_q;
    dir_t                  dir_next;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
        .clk(clk), .rst_n(rst_n), .button(button1), .press(press[0])
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
        .clk(clk), .rst_n(rst_n), .button(button2), .press(press[1])
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb3 (
        .clk(clk), .rst_n(rst_n), .button(button3), .press(press[2])
    );

    assign floor_vec = {floor3, floor2, floor1};

    always_comb begin
        set_req = '0;
        clr_req = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            set_req[i] = press[i] && !(door && last_floor == floor_t'(i + 1));
            clr_req[i] = floor_vec[i] && door && !moving;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            last_floor <= FLOOR_1;
        end else begin
            pending <= (pending | set_req) & ~clr_req;
            if ($onehot(floor_vec)) last_floor <= onehot_to_floor(floor_vec);
        end
    end

    // Ascending scan: first hit above is the nearest above, last hit below
    // is the nearest below.
    always_comb begin
        up_tgt       = FLOOR_NONE;
        dn_tgt       = FLOOR_NONE;
        here_pending = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i]) begin
                if (floor_t'(i + 1) > last_floor && up_tgt == FLOOR_NONE)
                    up_tgt = floor_t'(i + 1);
                if (floor_t'(i + 1) < last_floor)
                    dn_tgt = floor_t'(i + 1);
                if (floor_t'(i + 1) == last_floor)
                    here_pending = 1'b1;
            end
        end
    end

    always_comb begin
        dir_next    = DIR_IDLE;
        target_next = FLOOR_NONE;
        case (dir_q)
            DIR_DOWN: begin
                if (dn_tgt != FLOOR_NONE)      dir_next = DIR_DOWN;
                else if (up_tgt != FLOOR_NONE) dir_next = DIR_UP;
            end
            default: begin
                if (up_tgt != FLOOR_NONE)      dir_next = DIR_UP;
                else if (dn_tgt != FLOOR_NONE) dir_next = DIR_DOWN;
            end
        endcase
        case (dir_next)
            DIR_UP:   target_next = up_tgt;
            DIR_DOWN: target_next = dn_tgt;
            default:  target_next = here_pending ? last_floor : FLOOR_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q        <= DIR_IDLE;
            target       <= FLOOR_NONE;
            target_valid <= 1'b0;
        end else begin
            dir_q        <= dir_next;
            target       <= target_next;
            target_valid <= (target_next != FLOOR_NONE);
        end
    end

    assign dir  = dir_q;
    assign led1 = pending[0];
    assign led2 = pending[1];
    assign led3 = pending[2];

endmodule

// File: tb/tb_call_scheduler.sv
// Directed bench for call_scheduler with DEBOUNCE_CYCLES=3; inputs are
// driven and outputs sampled on the falling clock edge.
module tb_call_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       button1 = 1'b0, button2 = 1'b0, button3 = 1'b0;
    logic       floor1 = 1'b0, floor2 = 1'b0, floor3 = 1'b0;
    logic       door = 1'b0, moving = 1'b0;
    logic       led1, led2, led3;
    logic [1:0] target;
    logic       target_valid;
    logic [1:0] dir;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [7:0] D_IDLE = 8'd0, D_UP = 8'd1, D_DOWN = 8'd2;

    call_scheduler #(.DEBOUNCE_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .button1(button1), .button2(button2), .button3(button3),
        .floor1(floor1), .floor2(floor2), .floor3(floor3),
        .door(door), .moving(moving),
        .led1(led1), .led2(led2), .led3(led3),
        .target(target), .target_valid(target_valid), .dir(dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_button(input int f, input logic v);
        case (f)
            1: button1 = v;
            2: button2 = v;
            default: button3 = v;
        endcase
    endtask

    // Clean press: pending set 6 edges after the rise, dir/target one edge later.
    task automatic press(input int f);
        @(negedge clk);
        set_button(f, 1'b1);
        cycles(8);
        set_button(f, 1'b0);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
    endtask

    initial begin
        // Reset state
        cycles(2);
        check("rst_led1", {7'd0, led1}, 8'd0);
        check("rst_led2", {7'd0, led2}, 8'd0);
        check("rst_led3", {7'd0, led3}, 8'd0);
        check("rst_target", {6'd0, target}, 8'd0);
        check("rst_valid", {7'd0, target_valid}, 8'd0);
        check("rst_dir", {6'd0, dir}, D_IDLE);
        floor1 = 1'b1;
        rst_n  = 1'b1;
        cycles(4);

        // Bounce rejected, then clean hold accepted at 2+3+1 edges
        button2 = 1'b1; cycles(2);
        button2 = 1'b0; cycles(1);
        button2 = 1'b1; cycles(2);
        button2 = 1'b0; cycles(10);
        check("bounce_led2", {7'd0, led2}, 8'd0);
        button2 = 1'b1;
        cycles(5);
        check("hold_led2_early", {7'd0, led2}, 8'd0);
        cycles(1);
        check("hold_led2_on", {7'd0, led2}, 8'd1);
        cycles(1);
        check("hold_dir", {6'd0, dir}, D_UP);
        check("hold_target", {6'd0, target}, 8'd2);
        cycles(6);
        check("hold_led2_no_repeat", {7'd0, led2}, 8'd1);
        button2 = 1'b0;

        // Upward sweep from floor 1
        do_reset();
        press(3);
        check("sweep_led3", {7'd0, led3}, 8'd1);
        check("sweep_dir_up", {6'd0, dir}, D_UP);
        check("sweep_target3", {6'd0, target}, 8'd3);
        press(2);
        check("sweep_target2", {6'd0, target}, 8'd2);
        check("sweep_valid", {7'd0, target_valid}, 8'd1);
        @(negedge clk);
        floor1 = 1'b0; floor2 = 1'b1; door = 1'b1;
        @(negedge clk);
        check("sweep_led2_clear", {7'd0, led2}, 8'd0);
        @(negedge clk);
        check("sweep_target3_again", {6'd0, target}, 8'd3);
        check("sweep_dir_still_up", {6'd0, dir}, D_UP);

        // Reversal: last_floor stays 2 while floor 3 is served via multi-hot inputs
        door = 1'b0;
        press(1);
        check("rev_pre_target", {6'd0, target}, 8'd3);
        check("rev_pre_led1", {7'd0, led1}, 8'd1);
        floor3 = 1'b1; door = 1'b1;
        @(negedge clk);
        check("rev_led3_clear", {7'd0, led3}, 8'd0);
        check("rev_dir_still_up", {6'd0, dir}, D_UP);
        @(negedge clk);
        check("rev_dir_down", {6'd0, dir}, D_DOWN);
        check("rev_target1", {6'd0, target}, 8'd1);
        floor2 = 1'b0; floor3 = 1'b0; door = 1'b0;

        // Call at the open-door current floor is ignored; others are not
        do_reset();
        floor1 = 1'b1; door = 1'b1;
        cycles(2);
        press(1);
        check("served_led1", {7'd0, led1}, 8'd0);
        check("served_target", {6'd0, target}, 8'd0);
        check("served_dir", {6'd0, dir}, D_IDLE);
        press(2);
        check("served_other_led2", {7'd0, led2}, 8'd1);
        check("served_other_target", {6'd0, target}, 8'd2);
        door = 1'b0;

        // Between floors: everything held
        do_reset();
        floor1 = 1'b1;
        press(3);
        floor1 = 1'b0; moving = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("between_target", {6'd0, target}, 8'd3);
            check("between_dir", {6'd0, dir}, D_UP);
        end
        press(1);
        check("between_led1", {7'd0, led1}, 8'd1);
        check("between_target_kept", {6'd0, target}, 8'd3);

        // Asynchronous reset with pending=101, dir=UP
        check("async_pre_led3", {7'd0, led3}, 8'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_led1", {7'd0, led1}, 8'd0);
        check("async_led3", {7'd0, led3}, 8'd0);
        check("async_target", {6'd0, target}, 8'd0);
        check("async_valid", {7'd0, target_valid}, 8'd0);
        check("async_dir", {6'd0, dir}, D_IDLE);
        moving = 1'b0;

        // Button held across reset release must not register
        button1 = 1'b1; floor2 = 1'b1;
        cycles(2);
        rst_n = 1'b1;
        cycles(12);
        check("held_rst_led1", {7'd0, led1}, 8'd0);
        check("held_rst_dir", {6'd0, dir}, D_IDLE);
        button1 = 1'b0;
        press(1);
        check("rearm_led1", {7'd0, led1}, 8'd1);
        check("rearm_dir_down", {6'd0, dir}, D_DOWN);
        check("rearm_target1", {6'd0, target}, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
